mem_request_router: RTL and testbench

- Request-side counterpart of the three-way read-data mux.
- Buffers CPU load/store requests and decodes each address into one of three memory regions.
- Drives write enables and read strobes to the selected memory.
- Produces the registered MemorySelector and ReadValid that steer the read mux, aligned with the one-cycle synchronous-memory read latency.

---
 rtl/mem_request_router.sv | 164 ++++++++++++++++
 tb/tb_mem_request_router.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_router.sv
// Request-side router: buffers CPU load/store requests, decodes the head entry into one
// of three memory regions, strobes the selected memory and registers the read-mux select.
module mem_request_router #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH = 2,
    parameter logic [ADDR_W-1:0] BASE_2 = ADDR_W'(32'h0000_1000),
    parameter logic [ADDR_W-1:0] BASE_3 = ADDR_W'(32'h0000_2000),
    parameter logic [ADDR_W-1:0] LIMIT_3 = ADDR_W'(32'h0000_3000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddress,
    input  logic [DATA_W-1:0] ReqWriteData,
    input  logic              MemReady_1,
    input  logic              MemReady_2,
    input  logic              MemReady_3,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              WriteEnable_1,
    output logic              WriteEnable_2,
    output logic              WriteEnable_3,
    output logic              ReadEnable_1,
    output logic              ReadEnable_2,
    output logic              ReadEnable_3,
    output logic [1:0]        MemorySelector,
    output logic              ReadValid,
    output logic              AddrFault
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        REGION_1     = 2'b00,
        REGION_2     = 2'b01,
        REGION_3     = 2'b10,
        REGION_FAULT = 2'b11
    } region_e;

    logic              fifo_write [DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];
    logic [DATA_W-1:0] fifo_data  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    region_e           head_region;
    logic              head_fault;
    logic              target_ready;
    logic              strobe_fire;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign ReqReady = !full;
    assign push     = ReqValid && !full;

    assign head_write = fifo_write[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= ReqWrite;
            fifo_addr[wr_ptr]  <= ReqAddress;
            fifo_data[wr_ptr]  <= ReqWriteData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        if (head_addr < BASE_2) begin
            head_region = REGION_1;
        end else if (head_addr < BASE_3) begin
            head_region = REGION_2;
        end else if (head_addr < LIMIT_3) begin
            head_region = REGION_3;
        end else begin
            head_region = REGION_FAULT;
        end
    end

    assign head_fault = (head_region == REGION_FAULT);

    always_comb begin
        target_ready = 1'b0;
        case (head_region)
            REGION_1: target_ready = MemReady_1;
            REGION_2: target_ready = MemReady_2;
            REGION_3: target_ready = MemReady_3;
            default:  target_ready = 1'b0;
        endcase
    end

    // Fault entries never strobe a memory but still leave the FIFO.
    assign strobe_fire = !empty && !head_fault && target_ready;
    assign pop         = !empty && (head_fault || target_ready);

    always_comb begin
        Address       = '0;
        WriteData     = '0;
        WriteEnable_1 = 1'b0;
        WriteEnable_2 = 1'b0;
        WriteEnable_3 = 1'b0;
        ReadEnable_1  = 1'b0;
        ReadEnable_2  = 1'b0;
        ReadEnable_3  = 1'b0;
        if (!empty) begin
            Address   = head_addr;
            WriteData = head_data;
        end
        if (strobe_fire) begin
            WriteEnable_1 = head_write  && (head_region == REGION_1);
            WriteEnable_2 = head_write  && (head_region == REGION_2);
            WriteEnable_3 = head_write  && (head_region == REGION_3);
            ReadEnable_1  = !head_write && (head_region == REGION_1);
            ReadEnable_2  = !head_write && (head_region == REGION_2);
            ReadEnable_3  = !head_write && (head_region == REGION_3);
        end
    end

    // Select and valid are registered so they meet the synchronous memory read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemorySelector <= 2'b00;
            ReadValid      <= 1'b0;
            AddrFault      <= 1'b0;
        end else begin
            ReadValid <= pop && !head_write;
            AddrFault <= pop && head_fault;
            if (pop && !head_write) begin
                MemorySelector <= head_region;
            end
        end
    end

endmodule

// File: tb/tb_mem_request_router.sv
// Scoreboard bench for mem_request_router: a reference FIFO model predicts strobes,
// shared buses and the registered read-mux controls every cycle.
module tb_mem_request_router;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [31:0] ReqAddress;
    logic [31:0] ReqWriteData;
    logic        MemReady_1;
    logic        MemReady_2;
    logic        MemReady_3;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        WriteEnable_1;
    logic        WriteEnable_2;
    logic        WriteEnable_3;
    logic        ReadEnable_1;
    logic        ReadEnable_2;
    logic        ReadEnable_3;
    logic [1:0]  MemorySelector;
    logic        ReadValid;
    logic        AddrFault;

    mem_request_router #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (DEPTH),
        .BASE_2 (32'h0000_1000),
        .BASE_3 (32'h0000_2000),
        .LIMIT_3(32'h0000_3000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ReqValid      (ReqValid),
        .ReqReady      (ReqReady),
        .ReqWrite      (ReqWrite),
        .ReqAddress    (ReqAddress),
        .ReqWriteData  (ReqWriteData),
        .MemReady_1    (MemReady_1),
        .MemReady_2    (MemReady_2),
        .MemReady_3    (MemReady_3),
        .Address       (Address),
        .WriteData     (WriteData),
        .WriteEnable_1 (WriteEnable_1),
        .WriteEnable_2 (WriteEnable_2),
        .WriteEnable_3 (WriteEnable_3),
        .ReadEnable_1  (ReadEnable_1),
        .ReadEnable_2  (ReadEnable_2),
        .ReadEnable_3  (ReadEnable_3),
        .MemorySelector(MemorySelector),
        .ReadValid     (ReadValid),
        .AddrFault     (AddrFault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    req_t       sb[$];
    logic       exp_rv;
    logic       exp_fault;
    logic [1:0] exp_sel;
    logic       last_push;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic logic [1:0] region_of(input logic [31:0] a);
        if (a < 32'h0000_1000) return 2'd0;
        if (a < 32'h0000_2000) return 2'd1;
        if (a < 32'h0000_3000) return 2'd2;
        return 2'd3;
    endfunction

    // One clock: sample at the falling edge, score against the model, advance it,
    // then return 1 time unit after the rising edge so callers can drive inputs.
    task automatic step();
        req_t       h;
        logic [5:0] act_stb;
        logic [5:0] exp_stb;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        logic       pop;
        logic       push;
        logic       rdy;
        logic       exp_ready;
        logic [1:0] r;
        @(negedge clk);
        act_stb = {WriteEnable_1, WriteEnable_2, WriteEnable_3,
                   ReadEnable_1, ReadEnable_2, ReadEnable_3};
        if (!rst_n) begin
            sb.delete();
            exp_rv    = 1'b0;
            exp_fault = 1'b0;
            exp_sel   = 2'b00;
            last_push = 1'b0;
            n_cmp++;
            if (act_stb !== 6'b0) begin
                n_err++;
                $display("FAIL reset_strobes: got %b expected 000000", act_stb);
            end
            n_cmp++;
            if ({ReadValid, AddrFault, MemorySelector} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_regs: got rv=%b fault=%b sel=%b expected 0 0 00",
                         ReadValid, AddrFault, MemorySelector);
            end
            n_cmp++;
            if ({Address, WriteData} !== 64'h0) begin
                n_err++;
                $display("FAIL reset_bus: got addr=%h wdata=%h expected 0 0", Address, WriteData);
            end
        end else begin
            h       = '0;
            exp_stb = 6'b0;
            exp_a   = 32'h0;
            exp_d   = 32'h0;
            pop     = 1'b0;
            r       = 2'd0;
            if (sb.size() != 0) begin
                h     = sb[0];
                r     = region_of(h.a);
                exp_a = h.a;
                exp_d = h.d;
                case (r)
                    2'd0:    rdy = MemReady_1;
                    2'd1:    rdy = MemReady_2;
                    2'd2:    rdy = MemReady_3;
                    default: rdy = 1'b1;
                endcase
                pop = rdy;
                if (r != 2'd3 && rdy) begin
                    exp_stb = h.w ? (6'b100000 >> r) : (6'b000100 >> r);
                end
            end
            exp_ready = (sb.size() < DEPTH);
            n_cmp++;
            if (act_stb !== exp_stb) begin
                n_err++;
                $display("FAIL strobes: got %b expected %b", act_stb, exp_stb);
            end
            n_cmp++;
            if (Address !== exp_a || WriteData !== exp_d) begin
                n_err++;
                $display("FAIL bus: got addr=%h wdata=%h expected addr=%h wdata=%h",
                         Address, WriteData, exp_a, exp_d);
            end
            n_cmp++;
            if (ReadValid !== exp_rv || MemorySelector !== exp_sel) begin
                n_err++;
                $display("FAIL read_align: got rv=%b sel=%b expected rv=%b sel=%b",
                         ReadValid, MemorySelector, exp_rv, exp_sel);
            end
            n_cmp++;
            if (AddrFault !== exp_fault) begin
                n_err++;
                $display("FAIL addr_fault: got %b expected %b", AddrFault, exp_fault);
            end
            n_cmp++;
            if (ReqReady !== exp_ready) begin
                n_err++;
                $display("FAIL req_ready: got %b expected %b", ReqReady, exp_ready);
            end
            push      = ReqValid && exp_ready;
            exp_rv    = pop && !h.w;
            exp_fault = pop && (r == 2'd3);
            if (pop && !h.w) exp_sel = r;
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back('{w: ReqWrite, a: ReqAddress, d: ReqWriteData});
            last_push = push;
        end
        @(posedge clk);
        #1;
    endtask

    // Leaves ReqValid high on return so the caller may chain another request.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        ReqValid     = 1'b1;
        ReqWrite     = w;
        ReqAddress   = a;
        ReqWriteData = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_push && n < 20);
        n_cmp++;
        if (!last_push) begin
            n_err++;
            $display("FAIL accept_timeout: got no accept in %0d cycles expected accept", n);
        end
    endtask

    task automatic idle(input int cycles);
        ReqValid = 1'b0;
        repeat (cycles) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ReqReady !== 1'b1 || MemorySelector !== 2'b00 || ReadValid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b sel=%b rv=%b expected 1 00 0",
                     ReqReady, MemorySelector, ReadValid);
        end
        idle(2);
    endtask

    task automatic test_region_decode();
        MemReady_1 = 1'b1;
        MemReady_2 = 1'b1;
        MemReady_3 = 1'b1;
        send(1'b1, 32'h0000_0004, 32'hA5A5_0001);
        n_cmp++;
        if (WriteEnable_1 !== 1'b1 || Address !== 32'h0000_0004) begin
            n_err++;
            $display("FAIL decode_r1: got we1=%b addr=%h expected 1 00000004", WriteEnable_1, Address);
        end
        send(1'b1, 32'h0000_1004, 32'hA5A5_0001);
        n_cmp++;
        if (WriteEnable_2 !== 1'b1 || Address !== 32'h0000_1004) begin
            n_err++;
            $display("FAIL decode_r2: got we2=%b addr=%h expected 1 00001004", WriteEnable_2, Address);
        end
        send(1'b1, 32'h0000_2004, 32'hA5A5_0001);
        ReqValid = 1'b0;
        n_cmp++;
        if (WriteEnable_3 !== 1'b1 || WriteData !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL decode_r3: got we3=%b wdata=%h expected 1 a5a50001", WriteEnable_3, WriteData);
        end
        idle(3);
    endtask

    task automatic test_load_alignment();
        send(1'b0, 32'h0000_1010, 32'h0);
        ReqValid = 1'b0;
        n_cmp++;
        if (ReadEnable_2 !== 1'b1) begin
            n_err++;
            $display("FAIL load_strobe: got re2=%b expected 1", ReadEnable_2);
        end
        step();
        n_cmp++;
        if (ReadValid !== 1'b1 || MemorySelector !== 2'b01) begin
            n_err++;
            $display("FAIL load_align: got rv=%b sel=%b expected 1 01", ReadValid, MemorySelector);
        end
        step();
        n_cmp++;
        if (ReadValid !== 1'b0) begin
            n_err++;
            $display("FAIL load_rv_pulse: got rv=%b expected 0", ReadValid);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        MemReady_3 = 1'b0;
        send(1'b1, 32'h0000_2000, 32'h1111_0001);
        send(1'b1, 32'h0000_2000, 32'h1111_0002);
        ReqWriteData = 32'h1111_0003;
        repeat (3) step();
        n_cmp++;
        if (ReqReady !== 1'b0 || WriteEnable_3 !== 1'b0) begin
            n_err++;
            $display("FAIL bp_stall: got ready=%b we3=%b expected 0 0", ReqReady, WriteEnable_3);
        end
        ReqValid   = 1'b0;
        MemReady_3 = 1'b1;
        #1;
        n_cmp++;
        if (WriteEnable_3 !== 1'b1 || WriteData !== 32'h1111_0001) begin
            n_err++;
            $display("FAIL bp_drain1: got we3=%b wdata=%h expected 1 11110001", WriteEnable_3, WriteData);
        end
        step();
        n_cmp++;
        if (WriteEnable_3 !== 1'b1 || WriteData !== 32'h1111_0002) begin
            n_err++;
            $display("FAIL bp_drain2: got we3=%b wdata=%h expected 1 11110002", WriteEnable_3, WriteData);
        end
        step();
        n_cmp++;
        if (WriteEnable_3 !== 1'b0 || ReqReady !== 1'b1) begin
            n_err++;
            $display("FAIL bp_done: got we3=%b ready=%b expected 0 1", WriteEnable_3, ReqReady);
        end
        send(1'b1, 32'h0000_2000, 32'h1111_0003);
        idle(3);
    endtask

    task automatic test_fault();
        send(1'b0, 32'h0000_3000, 32'h0);
        ReqValid = 1'b0;
        n_cmp++;
        if ({WriteEnable_1, WriteEnable_2, WriteEnable_3,
             ReadEnable_1, ReadEnable_2, ReadEnable_3} !== 6'b0) begin
            n_err++;
            $display("FAIL fault_no_strobe: got a strobe expected none");
        end
        step();
        n_cmp++;
        if (AddrFault !== 1'b1 || ReadValid !== 1'b1 || MemorySelector !== 2'b11) begin
            n_err++;
            $display("FAIL fault_load: got fault=%b rv=%b sel=%b expected 1 1 11",
                     AddrFault, ReadValid, MemorySelector);
        end
        step();
        n_cmp++;
        if (AddrFault !== 1'b0 || ReadValid !== 1'b0) begin
            n_err++;
            $display("FAIL fault_pulse: got fault=%b rv=%b expected 0 0", AddrFault, ReadValid);
        end
        send(1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF);
        ReqValid = 1'b0;
        step();
        n_cmp++;
        if (AddrFault !== 1'b1 || ReadValid !== 1'b0 || MemorySelector !== 2'b11) begin
            n_err++;
            $display("FAIL fault_store: got fault=%b rv=%b sel=%b expected 1 0 11",
                     AddrFault, ReadValid, MemorySelector);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr_tab [8];
        addr_tab = '{32'h0000_0000, 32'h0000_0FFC, 32'h0000_1000, 32'h0000_1FFC,
                     32'h0000_2000, 32'h0000_2FFC, 32'h0000_3000, 32'hFFFF_FFFC};
        for (int i = 0; i < 300; i++) begin
            MemReady_1   = ($urandom_range(0, 3) != 0);
            MemReady_2   = ($urandom_range(0, 3) != 0);
            MemReady_3   = ($urandom_range(0, 3) != 0);
            ReqValid     = ($urandom_range(0, 3) != 0);
            ReqWrite     = $urandom_range(0, 1) == 1;
            ReqAddress   = addr_tab[$urandom_range(0, 7)];
            ReqWriteData = $urandom;
            step();
        end
        MemReady_1 = 1'b1;
        MemReady_2 = 1'b1;
        MemReady_3 = 1'b1;
        idle(5);
    endtask

    task automatic test_reset_midstream();
        MemReady_1 = 1'b0;
        send(1'b0, 32'h0000_0100, 32'h0);
        send(1'b0, 32'h0000_0104, 32'h0);
        ReqValid   = 1'b0;
        MemReady_1 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({WriteEnable_1, ReadEnable_1, ReadEnable_2, ReadEnable_3} !== 4'b0) begin
            n_err++;
            $display("FAIL midreset_drop: got re1=%b expected 0", ReadEnable_1);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ReadEnable_1 !== 1'b0 || ReqReady !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_stale: got re1=%b ready=%b expected 0 1", ReadEnable_1, ReqReady);
        end
        idle(4);
    endtask

    initial begin
        rst_n        = 1'b0;
        ReqValid     = 1'b0;
        ReqWrite     = 1'b0;
        ReqAddress   = 32'h0;
        ReqWriteData = 32'h0;
        MemReady_1   = 1'b1;
        MemReady_2   = 1'b1;
        MemReady_3   = 1'b1;
        exp_rv       = 1'b0;
        exp_fault    = 1'b0;
        exp_sel      = 2'b00;
        last_push    = 1'b0;
        test_reset();
        test_region_decode();
        test_load_alignment();
        test_backpressure();
        test_fault();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
